// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : hazard/stall/flush controller for a 5-stage pipeline; arbitrates a data-memory freeze,
//           taken-branch flush and load-use bubble, and keeps saturating stall/flush counters.
// Latency : enables and flushes are combinational (same cycle); state, counters and timeout are registered.
// Backpressure: dmem_req & ~dmem_ready freezes every stage; a branch or load-use seen during the freeze
//           is re-evaluated once memory completes, so it is deferred rather than dropped.
// Ports   : clk/rst (async active-high), decode/exec hazard inputs, mem_branch_taken, dmem_req/ready,
//           stage enables and flushes, stall_cnt/flush_cnt, mem_timeout (sticky), state (RUN/MEM_WAIT/FLUSH).
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs,
    input  logic [4:0]       dec_rt,
    input  logic             dec_uses_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_dec_en,
    output logic             dec_exec_en,
    output logic             exec_mem_en,
    output logic             mem_wb_en,
    output logic             if_dec_flush,
    output logic             dec_exec_flush,
    output logic             exec_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_timeout;

    logic              w_load_use;
    logic              w_mem_stall;
    logic              w_branch;
    logic              w_lu_applied;
    logic [WAIT_W-1:0] w_wait_nxt;

    assign w_load_use = dec_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                        ((ex_rd == dec_rs) | (dec_uses_rt & (ex_rd == dec_rt)));
    assign w_mem_stall = dmem_req & ~dmem_ready;

    // The cycle after a flush has the bubble sitting in Mem, so a still-high
    // mem_branch_taken there is stale and must not flush a second time.
    assign w_branch     = ~w_mem_stall & mem_branch_taken & (r_state != FLUSH);
    assign w_lu_applied = ~w_mem_stall & ~w_branch & w_load_use;

    // Wait counter saturates at TIMEOUT so it can never wrap back below it.
    assign w_wait_nxt = (r_wait_cnt == WAIT_W'(TIMEOUT)) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

    always_comb begin
        pc_en          = 1'b0;
        if_dec_en      = 1'b0;
        dec_exec_en    = 1'b0;
        exec_mem_en    = 1'b0;
        mem_wb_en      = 1'b0;
        if_dec_flush   = 1'b0;
        dec_exec_flush = 1'b0;
        exec_mem_flush = 1'b0;
        if (!rst && !w_mem_stall) begin
            pc_en       = 1'b1;
            if_dec_en   = 1'b1;
            dec_exec_en = 1'b1;
            exec_mem_en = 1'b1;
            mem_wb_en   = 1'b1;
            if (w_branch) begin
                if_dec_flush   = 1'b1;
                dec_exec_flush = 1'b1;
                exec_mem_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/DEC, push a bubble into EX: one-cycle stall.
                pc_en          = 1'b0;
                if_dec_en      = 1'b0;
                dec_exec_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_mem_stall) begin
                r_state <= MEM_WAIT;
            end else if (w_branch) begin
                r_state <= FLUSH;
            end else if (r_state == MEM_WAIT && !dmem_ready) begin
                r_state <= MEM_WAIT;
            end else begin
                r_state <= RUN;
            end

            if (w_mem_stall) begin
                r_wait_cnt <= w_wait_nxt;
                if (w_wait_nxt == WAIT_W'(TIMEOUT)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            if ((w_mem_stall || w_lu_applied) && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch && r_flush_cnt != {CNT_W{1'b1}}) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_timeout = r_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : randomized + directed bench for pipeline_hazard_ctrl with a queue-based scoreboard.
// Latency : expected values are pushed when a cycle's inputs are applied and popped on the falling edge.
// Backpressure: none; the DUT presents an output every cycle, so one entry is consumed per cycle.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 8;
    localparam int TO = 16;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic dec_valid, dec_uses_rt, ex_memread, ex_regwrite, mem_branch_taken, dmem_req, dmem_ready;
    logic [4:0] dec_rs, dec_rt, ex_rd;
    logic pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en;
    logic if_dec_flush, dec_exec_flush, exec_mem_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic mem_timeout;
    logic [1:0] state;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_dec_en(if_dec_en), .dec_exec_en(dec_exec_en),
        .exec_mem_en(exec_mem_en), .mem_wb_en(mem_wb_en),
        .if_dec_flush(if_dec_flush), .dec_exec_flush(dec_exec_flush), .exec_mem_flush(exec_mem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout), .state(state)
    );

    typedef struct packed {
        logic [4:0]    en;   // {pc, if_dec, dec_exec, exec_mem, mem_wb}
        logic [2:0]    fl;   // {if_dec, dec_exec, exec_mem}
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          to;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: mode 0=RUN 1=MEM_WAIT 2=FLUSH, plus plain integer counters.
    int m_mode, m_run, m_sc, m_fc;
    bit m_to;

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    task automatic issue();
        obs_t e;
        bit hazard, stall, br;
        int nxt;
        if (rst) begin
            m_mode = 0; m_run = 0; m_sc = 0; m_fc = 0; m_to = 0;
            e = '0;
            exp_q.push_back(e);
            return;
        end
        e.st = 2'(m_mode);
        e.sc = CW'(m_sc);
        e.fc = CW'(m_fc);
        e.to = m_to;
        hazard = dec_valid && ex_memread && ex_regwrite && ex_rd != 0 &&
                 (ex_rd == dec_rs || (dec_uses_rt && ex_rd == dec_rt));
        stall = dmem_req && !dmem_ready;
        br = mem_branch_taken && m_mode != 2;
        e.fl = 3'b000;
        if (stall) begin
            e.en = 5'b00000;
            m_sc = sat_inc(m_sc);
            m_run++;
            if (m_run >= TO) m_to = 1;
            nxt = 1;
        end else begin
            m_run = 0;
            nxt = (m_mode == 1 && !dmem_ready) ? 1 : 0;
            if (br) begin
                e.en = 5'b11111; e.fl = 3'b111;
                m_fc = sat_inc(m_fc);
                nxt = 2;
            end else if (hazard) begin
                e.en = 5'b00111; e.fl = 3'b010;
                m_sc = sat_inc(m_sc);
            end else begin
                e.en = 5'b11111;
            end
        end
        m_mode = nxt;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        obs_t e, o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = '{en: {pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en},
                      fl: {if_dec_flush, dec_exec_flush, exec_mem_flush},
                      st: state, sc: stall_cnt, fc: flush_cnt, to: mem_timeout};
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL scoreboard cyc=%0d got en=%b fl=%b st=%0d sc=%0d fc=%0d to=%b exp en=%b fl=%b st=%0d sc=%0d fc=%0d to=%b",
                             cyc, o.en, o.fl, o.st, o.sc, o.fc, o.to, e.en, e.fl, e.st, e.sc, e.fc, e.to);
                end
            end
        end
    end

    task automatic dchk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
        end
    endtask

    task automatic go();
        issue();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 0; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_uses_rt = 0;
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
        mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        go();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        go();
        dchk("rst_state", state, 0);
        dchk("rst_pc_en", pc_en, 0);
        dchk("rst_stall_cnt", stall_cnt, 0);
        rst = 0;
        go();

        // Load-use on rs, then the r0 exemption.
        do_reset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; dec_rs = 5; dec_valid = 1;
        #1;
        dchk("lu_pc_en", pc_en, 0);
        dchk("lu_if_dec_en", if_dec_en, 0);
        dchk("lu_dec_exec_flush", dec_exec_flush, 1);
        go();
        dchk("lu_stall_cnt", stall_cnt, 1);
        ex_rd = 0; dec_rs = 0;
        #1;
        dchk("lu_r0_pc_en", pc_en, 1);
        go();

        // rt is only a hazard when the instruction actually reads it.
        ex_rd = 7; dec_rt = 7; dec_rs = 3; dec_uses_rt = 0;
        #1;
        dchk("rt_unused_pc_en", pc_en, 1);
        go();
        dec_uses_rt = 1;
        #1;
        dchk("rt_used_pc_en", pc_en, 0);
        go();

        // Branch held two cycles: flush once only.
        do_reset();
        mem_branch_taken = 1;
        #1;
        dchk("br1_flushes", {if_dec_flush, dec_exec_flush, exec_mem_flush}, 7);
        go();
        dchk("br1_flush_cnt", flush_cnt, 1);
        dchk("br1_state", state, 2);
        dchk("br2_flushes", {if_dec_flush, dec_exec_flush, exec_mem_flush}, 0);
        go();
        dchk("br2_flush_cnt", flush_cnt, 1);
        idle();
        go();

        // Three-cycle memory wait.
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            dchk("mw_enables", {pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en}, 0);
            go();
            dchk("mw_state", state, 1);
        end
        dmem_ready = 1;
        go();
        dchk("mw_exit_state", state, 0);
        dchk("mw_stall_cnt", stall_cnt, 3);
        dchk("mw_timeout", mem_timeout, 0);

        // Timeout with a branch arriving mid-wait.
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) mem_branch_taken = 1;
            go();
            if (i == 15) dchk("to_before", mem_timeout, 0);
            if (i == 16) dchk("to_at16", mem_timeout, 1);
        end
        dchk("to_no_early_flush", flush_cnt, 0);
        dmem_ready = 1;
        #1;
        dchk("to_branch_after_ready", exec_mem_flush, 1);
        go();
        dchk("to_flush_cnt", flush_cnt, 1);
        dchk("to_sticky", mem_timeout, 1);
        idle();
        go();
        dchk("to_sticky2", mem_timeout, 1);

        // Counter saturation, then reset in the middle of a wait.
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        repeat ((1 << CW) + 3) go();
        dchk("sat_stall_cnt", stall_cnt, SAT);
        rst = 1;
        #1;
        dchk("rst_mid_pc_en", pc_en, 0);
        go();
        dchk("rst_mid_state", state, 0);
        dchk("rst_mid_stall_cnt", stall_cnt, 0);
        dchk("rst_mid_timeout", mem_timeout, 0);
        idle();
        mem_branch_taken = 1;
        repeat (2 * ((1 << CW) + 3)) go();
        dchk("sat_flush_cnt", flush_cnt, SAT);

        // Random traffic with a small register space so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            dec_valid = $urandom_range(0, 3) != 0;
            dec_rs = 5'($urandom_range(0, 3));
            dec_rt = 5'($urandom_range(0, 3));
            dec_uses_rt = 1'($urandom);
            ex_memread = $urandom_range(0, 1) != 0;
            ex_regwrite = $urandom_range(0, 3) != 0;
            ex_rd = 5'($urandom_range(0, 3));
            mem_branch_taken = $urandom_range(0, 4) == 0;
            dmem_req = $urandom_range(0, 2) == 0;
            dmem_ready = $urandom_range(0, 3) == 0;
            go();
        end

        idle();
        go();
        @(negedge clk);
        #1;
        dchk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
